// File: rtl/imem_wb.sv
// LEGv8 memory-access + write-back stage: EX/MEM and MEM/WB registers, data memory.
// Optional out-of-range access detection: define DMEM_FAULT_EN.

`ifndef WORD
`define WORD 64
`endif

module imem_wb #(
    parameter int DMEM_DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [`WORD-1:0]   alu_result,
    input  logic [`WORD-1:0]   read_data2,
    input  logic [`WORD-1:0]   branch_target_in,
    input  logic               zero,
    input  logic               branch,
    input  logic               uncond_branch,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    input  logic               reg_write_in,
    input  logic [4:0]         write_register_in,
    output logic               pc_src,
    output logic [`WORD-1:0]   branch_target_out,
    output logic [`WORD-1:0]   write_data,
    output logic [4:0]         write_register_out,
    output logic               reg_write_out,
    output logic               mem_fault
);

    localparam int W  = `WORD;
    localparam int AW = $clog2(DMEM_DEPTH);

    logic [W-1:0]  ex_alu_q;
    logic [W-1:0]  ex_rd2_q;
    logic [W-1:0]  ex_bt_q;
    logic          ex_zero_q;
    logic          ex_br_q;
    logic          ex_ub_q;
    logic          ex_mr_q;
    logic          ex_mw_q;
    logic          ex_m2r_q;
    logic          ex_rw_q;
    logic [4:0]    ex_wr_q;

    logic [W-1:0]  wb_rdata_q;
    logic [W-1:0]  wb_alu_q;
    logic          wb_m2r_q;
    logic          wb_rw_q;
    logic [4:0]    wb_wr_q;

    logic [W-1:0]  mem_q [DMEM_DEPTH];

    logic [AW-1:0] idx;
    logic          oor;
    logic          wr_en;
    logic [W-1:0]  rdata_d;

    assign idx = ex_alu_q[3 +: AW];

`ifdef DMEM_FAULT_EN
    localparam logic [W-4:0] DEPTH_W = (W-3)'(DMEM_DEPTH);

    logic mem_fault_q;
    logic mem_fault_d;

    assign oor = (ex_mr_q | ex_mw_q) && (ex_alu_q[W-1:3] >= DEPTH_W);

    // Sticky fault flag: set by any out-of-range access, cleared only by reset.
    always_comb begin
        mem_fault_d = mem_fault_q | oor;
    end

    // Fault flag register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_fault_q <= 1'b0;
        end else begin
            mem_fault_q <= mem_fault_d;
        end
    end

    assign mem_fault = mem_fault_q;
`else
    assign oor       = 1'b0;
    assign mem_fault = 1'b0;
`endif

    assign wr_en = ex_mw_q & ~oor;

    // Combinational read from the EX/MEM address; zero when not loading.
    always_comb begin
        rdata_d = '0;
        if (ex_mr_q && !oor) begin
            rdata_d = mem_q[idx];
        end
    end

    // EX/MEM pipeline register: captures everything execute hands over.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_alu_q  <= '0;
            ex_rd2_q  <= '0;
            ex_bt_q   <= '0;
            ex_zero_q <= 1'b0;
            ex_br_q   <= 1'b0;
            ex_ub_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            ex_mw_q   <= 1'b0;
            ex_m2r_q  <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_wr_q   <= '0;
        end else begin
            ex_alu_q  <= alu_result;
            ex_rd2_q  <= read_data2;
            ex_bt_q   <= branch_target_in;
            ex_zero_q <= zero;
            ex_br_q   <= branch;
            ex_ub_q   <= uncond_branch;
            ex_mr_q   <= mem_read;
            ex_mw_q   <= mem_write;
            ex_m2r_q  <= mem_to_reg;
            ex_rw_q   <= reg_write_in;
            ex_wr_q   <= write_register_in;
        end
    end

    // Data memory: reset wipes every word and drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= ex_rd2_q;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_wr_q    <= '0;
        end else begin
            wb_rdata_q <= rdata_d;
            wb_alu_q   <= ex_alu_q;
            wb_m2r_q   <= ex_m2r_q;
            wb_rw_q    <= ex_rw_q;
            wb_wr_q    <= ex_wr_q;
        end
    end

    assign pc_src             = ex_ub_q | (ex_br_q & ex_zero_q);
    assign branch_target_out  = ex_bt_q;
    assign write_data         = wb_m2r_q ? wb_rdata_q : wb_alu_q;
    assign write_register_out = wb_wr_q;
    assign reg_write_out      = wb_rw_q;

endmodule

// File: tb/tb_imem_wb.sv
// Scoreboard bench for imem_wb: random + directed traffic against a
// word-addressed memory model; expectations queued per cycle, checked at negedge.

module tb_imem_wb;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] alu_result, read_data2, branch_target_in;
    logic        zero, branch, uncond_branch, mem_read, mem_write;
    logic        mem_to_reg, reg_write_in;
    logic [4:0]  write_register_in;
    logic        pc_src;
    logic [63:0] branch_target_out, write_data;
    logic [4:0]  write_register_out;
    logic        reg_write_out, mem_fault;

    imem_wb #(.DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .read_data2(read_data2),
        .branch_target_in(branch_target_in), .zero(zero),
        .branch(branch), .uncond_branch(uncond_branch),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write_in(reg_write_in),
        .write_register_in(write_register_in),
        .pc_src(pc_src), .branch_target_out(branch_target_out),
        .write_data(write_data), .write_register_out(write_register_out),
        .reg_write_out(reg_write_out), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        pc;
        logic [63:0] bt;
        logic [63:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [63:0] mdl_mem [DEPTH];
    bit          pend_v;
    int          pend_idx;
    logic [63:0] pend_data;
    logic [63:0] pwb_wd;
    logic [4:0]  pwb_wr;
    logic        pwb_rw;
    bit          mdl_fault;
    bit          prev_oor;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h",
                     name, cyc, act, req);
        end
    endtask

    // Monitor: compare the expectation tagged for the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_expect tag=%0d actual=none required=cyc%0d",
                     exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_src", 64'(pc_src), 64'(e.pc));
            chk("branch_target", branch_target_out, e.bt);
            chk("write_data", write_data, e.wd);
            chk("write_register", 64'(write_register_out), 64'(e.wr));
            chk("reg_write", 64'(reg_write_out), 64'(e.rw));
            chk("mem_fault", 64'(mem_fault), 64'(e.flt));
        end
    end

    // Present one instruction (or a reset cycle) for the next edge.
    task automatic issue(bit rst_n, logic [63:0] alu, logic [63:0] sd,
                         logic [63:0] bt, bit z, bit br, bit ub, bit mr,
                         bit mw, bit m2r, bit rw, logic [4:0] wr);
        exp_t        e;
        bit          oor;
        int          ix;
        logic [63:0] rdata;
        logic [63:0] widx;
        reset = rst_n;
        alu_result = alu; read_data2 = sd; branch_target_in = bt;
        zero = z; branch = br; uncond_branch = ub;
        mem_read = mr; mem_write = mw; mem_to_reg = m2r;
        reg_write_in = rw; write_register_in = wr;
        e.cyc = cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            pend_v = 0; pwb_wd = '0; pwb_wr = '0; pwb_rw = 0;
            mdl_fault = 0; prev_oor = 0;
            e.pc = 0; e.bt = '0; e.wd = '0; e.wr = '0; e.rw = 0; e.flt = 0;
        end else begin
            if (pend_v) mdl_mem[pend_idx] = pend_data;
            pend_v = 0;
            mdl_fault = mdl_fault | prev_oor;
            e.pc = ub | (br & z);
            e.bt = bt;
            e.wd = pwb_wd; e.wr = pwb_wr; e.rw = pwb_rw;
            e.flt = mdl_fault;
            widx = alu / 8;
`ifdef DMEM_FAULT_EN
            oor = (mr | mw) && (widx >= 64'(DEPTH));
`else
            oor = 0;
`endif
            ix = int'(widx % 64'(DEPTH));
            rdata = (mr && !oor) ? mdl_mem[ix] : 64'd0;
            pwb_wd = m2r ? rdata : alu;
            pwb_wr = wr; pwb_rw = rw;
            if (mw && !oor) begin
                pend_v = 1; pend_idx = ix; pend_data = sd;
            end
            prev_oor = oor;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_instr();
        logic [63:0] a;
        int          sel;
        sel = $urandom_range(0, 3);
        if (sel == 3) a = {$urandom, $urandom};
        else a = 64'($urandom_range(0, 16 * DEPTH - 1));
        issue(($urandom_range(0, 19) != 0), a, {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom), 1'($urandom),
              ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom));
    endtask

    initial begin
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load 0x10 -> X5
        issue(1, 64'h10, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5);
        bubble(); bubble();
        // store then load same address next cycle
        issue(1, 64'h18, 64'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        issue(1, 64'h18, 0, 0, 0, 0, 0, 1, 0, 1, 1, 9);
        bubble(); bubble();
        // branches, target 0x40
        issue(1, 0, 0, 64'h40, 1, 1, 0, 0, 0, 0, 0, 0);
        bubble();
        issue(1, 0, 0, 64'h40, 0, 1, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 64'h40, 0, 0, 1, 0, 0, 0, 0, 0);
        bubble();
        // R-type
        issue(1, 64'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        bubble(); bubble();
        // store discarded by reset, reg_write held low in reset
        issue(1, 64'h20, 64'h55, 0, 0, 0, 0, 0, 1, 0, 1, 7);
        issue(0, 64'h20, 0, 0, 0, 0, 0, 1, 0, 1, 1, 4);
        issue(1, 64'h20, 0, 0, 0, 0, 0, 1, 0, 1, 1, 4);
        bubble(); bubble();
        // store just past the end, then load 0x0
        issue(1, 64'(8 * DEPTH), 64'h1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        bubble();
        issue(1, 64'h0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6);
        bubble(); bubble(); bubble();
        // randomized traffic
        for (int i = 0; i < 600; i++) rand_instr();
        bubble(); bubble(); bubble();
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_wb.md
# imem_wb

Combined memory-access and write-back stage of the LEGv8 pipeline, fed by the execute stage. Holds the EX/MEM and MEM/WB pipeline registers and the doubleword data memory. Drives `pc_src`/`branch_target` back to fetch and `write_data`/`write_register`/`reg_write` back to decode's register file, which closes both feedback paths of the pipeline.

## Interface
- `DMEM_DEPTH`, 64: data memory depth in doublewords; must be a power of two, ≥ 2.
- Word width is the codebase-wide `` `WORD `` (64) from `definitions.vh`. It is not a parameter.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `alu_result`  in  `WORD`  ALU result from execute; the byte address for loads and stores.
- `read_data2`  in  `WORD`  store data from execute.
- `branch_target_in`  in  `WORD`  branch target computed in execute.
- `zero`  in  1  ALU zero flag.
- `branch`, `uncond_branch`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write_in`  in  1 each  control bits from execute.
- `write_register_in`  in  5  destination register number.
- `pc_src`  out  1  redirect fetch to `branch_target_out`.
- `branch_target_out`  out  `WORD`  registered branch target.
- `write_data`  out  `WORD`  register-file write data.
- `write_register_out`  out  5  register-file write address.
- `reg_write_out`  out  1  register-file write enable.
- `mem_fault`  out  1  sticky out-of-range access flag (see Configuration).

## Operation
- EX/MEM register: on every edge with `reset`=1, capture all execute inputs.
- Branch resolution uses the EX/MEM copies only: `pc_src` = `uncond_branch_m` | (`branch_m` & `zero_m`). `branch_target_out` = `branch_target_m`.
- Data memory:
  - Array of `DMEM_DEPTH` words.
  - Index = `alu_result_m[3 +: log2(DMEM_DEPTH)]`. Address bits [2:0] are ignored; no misalignment detection.
  - Read is combinational from the EX/MEM address.
  - Write happens on the rising edge when `mem_write_m`=1 and `reset`=1.
- `mem_read` and `mem_write` both set: the write occurs, and the read returns the old contents.
- Read data while `mem_read_m`=0 is 64'b0.
- MEM/WB register: captures `read_data`, `alu_result_m`, `mem_to_reg_m`, `reg_write_m`, and `write_register_m`.
- Write-back mux: `write_data` = `mem_to_reg_w` ? `read_data_w` : `alu_result_w`. This path is combinational from MEM/WB.
- No hazard detection, no forwarding, and no flush of younger instructions; those belong upstream.

## Timing
- An instruction captured at edge N:
  - `pc_src`, `branch_target_out`, and the memory read are valid during cycle N→N+1.
  - A store commits at edge N+1.
  - `write_data`, `write_register_out`, and `reg_write_out` are valid during cycle N+1→N+2.
- Store followed by a load to the same address on the next cycle: the load reads the new value, because the store commits at the edge where the load enters EX/MEM.
- Reset (`reset`=0 at an edge):
  - All pipeline registers clear to 0, so `pc_src`=0, `branch_target_out`=0, `write_data`=0, `write_register_out`=0, `reg_write_out`=0.
  - Every memory word clears to 0.
  - `mem_fault` clears to 0.
  - A store held in EX/MEM at that edge is discarded.
  - Outputs are 0 from the first reset edge until the first non-reset capture plus stage latency.
- Reset mid-operation behaves identically, with no partial write-back.

## Configuration
- `DMEM_FAULT_EN` defined:
  - An access with `mem_read_m` | `mem_write_m` and `alu_result_m[63:3]` ≥ `DMEM_DEPTH` is out of range.
  - An out-of-range read returns 0.
  - An out-of-range write is suppressed.
  - `mem_fault` sets at that edge and holds until reset.
- `DMEM_FAULT_EN` undefined: the index wraps modulo `DMEM_DEPTH`, and `mem_fault` is tied to 0.

## Test plan
- Reset, then release:
  - All outputs are 0.
  - A load from address 0x10 with `mem_to_reg`=1, `reg_write`=1, `wr`=X5 gives `write_data`=0, `write_register_out`=5, `reg_write_out`=1, two edges after capture.
- Store 0xDEADBEEF to 0x18, then next cycle load 0x18 to X9: `write_data`=0xDEADBEEF two edges after the load's capture.
- Branch cases, each with target 0x40:
  - `branch`=1, `zero`=1: `pc_src`=1 for exactly one cycle, `branch_target_out`=0x40.
  - `zero`=0: `pc_src`=0.
  - `uncond_branch`=1, `zero`=0: `pc_src`=1.
- R-type result 0x7 with `mem_to_reg`=0, `reg_write`=1, `wr`=X3: `write_data`=0x7, `write_register_out`=3.
- Store 0x55 to 0x20, then assert reset at the following edge: a later load from 0x20 returns 0 and `reg_write_out`=0 during reset.
- Store 0x1 to byte address 8·`DMEM_DEPTH`:
  - With `DMEM_FAULT_EN`: `mem_fault`=1 sticky, and a load from 0x0 returns 0.
  - Without it: a load from 0x0 returns 0x1 and `mem_fault`=0.
